// File: rtl/tohost_monitor.sv
`timescale 1ns/1ps
// Snoops stores to the tohost word and turns them, a retire watchdog or a cycle budget into a sticky verdict.
// Optional console putchar decode is enabled by defining TOHOST_CONSOLE_EN.
module tohost_monitor #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h8000_1000,
  parameter int                HANG_LIMIT   = 10000,
  parameter int                DRAIN_CYCLES = 4,
  parameter int                CYC_W        = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        wr_strb,
  input  logic              retire_valid,
  input  logic [CYC_W-1:0]  max_cycles,
  output logic              finish,
  output logic              failure,
  output logic [2:0]        reason,
  output logic [62:0]       exit_code,
  output logic [CYC_W-1:0]  cycle_count
`ifdef TOHOST_CONSOLE_EN
  ,
  output logic              console_valid,
  output logic [7:0]        console_char
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] R_NONE      = 3'd0;
  localparam logic [2:0] R_PASS      = 3'd1;
  localparam logic [2:0] R_EXIT_FAIL = 3'd2;
  localparam logic [2:0] R_HANG      = 3'd3;
  localparam logic [2:0] R_TIMEOUT   = 3'd4;

  localparam int              DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [1:0]      ST_EVENT   = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
  localparam logic [CYC_W-1:0] HANG_TGT  = CYC_W'((HANG_LIMIT > 0) ? HANG_LIMIT - 1 : 0);

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [DW-1:0]    drain_cnt;
  logic [CYC_W-1:0] hang_cnt;
  logic [63:0]      eff_data;
  logic             addr_hit;
  logic             putchar;
  logic             tohost_exit;
  logic             hang_hit;
  logic             timeout_hit;
  logic [2:0]       exit_reason;

  // An all-zero effective store is the host clearing tohost, not a verdict.
  assign eff_data    = mask_bytes(wr_data, wr_strb);
  assign addr_hit    = wr_valid && (wr_addr == TOHOST_ADDR) && wr_strb[0] && (eff_data != 64'd0);
`ifdef TOHOST_CONSOLE_EN
  assign putchar     = (eff_data[63:56] == 8'h01) && (eff_data[55:48] == 8'h01);
`else
  assign putchar     = 1'b0;
`endif
  assign tohost_exit = addr_hit && !putchar;
  assign hang_hit    = (HANG_LIMIT != 0) && (hang_cnt == HANG_TGT) && !retire_valid;
  assign timeout_hit = (max_cycles != '0) && (cycle_count >= max_cycles);
  assign exit_reason = (eff_data == 64'd1) ? R_PASS : R_EXIT_FAIL;

  assign wr_ready = 1'b1;
  assign finish   = (state == ST_DONE) && (reason == R_PASS);
  assign failure  = (state == ST_DONE) && (reason != R_PASS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      reason      <= R_NONE;
      exit_code   <= '0;
      cycle_count <= '0;
      hang_cnt    <= '0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_count <= cycle_count + 1'b1;
          hang_cnt    <= retire_valid ? '0 : sat_inc(hang_cnt);
          if (tohost_exit) begin
            reason    <= exit_reason;
            exit_code <= eff_data[63:1];
            drain_cnt <= DRAIN_LOAD;
            state     <= ST_EVENT;
          end else if (hang_hit) begin
            reason    <= R_HANG;
            drain_cnt <= DRAIN_LOAD;
            state     <= ST_EVENT;
          end else if (timeout_hit) begin
            reason    <= R_TIMEOUT;
            drain_cnt <= DRAIN_LOAD;
            state     <= ST_EVENT;
          end
        end
        ST_DRAIN: begin
          // Leaving on the last count makes the verdict visible exactly DRAIN_CYCLES+1 cycles after the event.
          cycle_count <= cycle_count + 1'b1;
          if (drain_cnt <= DW'(1)) state <= ST_DONE;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
        ST_DONE: ;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef TOHOST_CONSOLE_EN
  always_ff @(posedge clock) begin
    if (reset) console_valid <= 1'b0;
    else       console_valid <= (state == ST_RUN) && addr_hit && putchar;
  end

  always_ff @(posedge clock) begin
    if ((state == ST_RUN) && addr_hit && putchar) console_char <= eff_data[7:0];
  end
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
`timescale 1ns/1ps
// Bench for tohost_monitor: a vector table of single tohost writes plus multi-cycle sequences,
// with verdict expectations queued at stimulus time and checked on their due cycle.
module tb_tohost_monitor;

  localparam int          D      = 4;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clock, reset, wr_valid, wr_ready, retire_valid;
  logic [31:0] wr_addr;
  logic [63:0] wr_data, max_cycles, cycle_count;
  logic [7:0]  wr_strb;
  logic        finish, failure;
  logic [2:0]  reason;
  logic [62:0] exit_code;
`ifdef TOHOST_CONSOLE_EN
  logic        console_valid;
  logic [7:0]  console_char;
`endif

  tohost_monitor #(
    .ADDR_W(32), .TOHOST_ADDR(TOHOST), .HANG_LIMIT(20), .DRAIN_CYCLES(D), .CYC_W(64)
  ) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .retire_valid(retire_valid),
    .max_cycles(max_cycles), .finish(finish), .failure(failure), .reason(reason),
    .exit_code(exit_code), .cycle_count(cycle_count)
`ifdef TOHOST_CONSOLE_EN
    , .console_valid(console_valid), .console_char(console_char)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [31:0] off;
    logic [7:0]  strb;
    logic        fin;
    logic        fail;
    logic [2:0]  rsn;
    logic [62:0] code;
  } vec_t;

  typedef struct {
    int          due;
    string       name;
    logic        fin;
    logic        fail;
    logic [2:0]  rsn;
    logic [62:0] code;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    if (sb.size() > 0) begin
      if (cyc == sb[0].due - 1)
        chk({sb[0].name, "_early"}, 64'({finish, failure}), 64'(0));
      if (cyc == sb[0].due) begin
        chk({sb[0].name, "_finish"},  64'(finish),    64'(sb[0].fin));
        chk({sb[0].name, "_failure"}, 64'(failure),   64'(sb[0].fail));
        chk({sb[0].name, "_reason"},  64'(reason),    64'(sb[0].rsn));
        chk({sb[0].name, "_exit"},    64'(exit_code), 64'(sb[0].code));
        void'(sb.pop_front());
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_at(input int due, input string nm, input logic f, input logic fl,
                           input logic [2:0] r, input logic [62:0] e);
    exp_t x;
    x.due = due; x.name = nm; x.fin = f; x.fail = fl; x.rsn = r; x.code = e;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [63:0] d, input logic [31:0] off, input logic [7:0] s);
    wr_valid = 1'b1;
    wr_addr  = TOHOST + off;
    wr_data  = d;
    wr_strb  = s;
    step();
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_strb  = '0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_finish"},  64'(finish),      64'(0));
    chk({nm, "_failure"}, 64'(failure),     64'(0));
    chk({nm, "_reason"},  64'(reason),      64'(0));
    chk({nm, "_exit"},    64'(exit_code),   64'(0));
    chk({nm, "_cycles"},  cycle_count,      64'(0));
    chk({nm, "_ready"},   64'(wr_ready),    64'(1));
`ifdef TOHOST_CONSOLE_EN
    chk({nm, "_console"}, 64'(console_valid), 64'(0));
`endif
  endtask

  task automatic do_reset();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();
    reset        = 1'b1;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    wr_strb      = '0;
    retire_valid = 1'b1;
    max_cycles   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0]  = '{"pass",     64'h1,                    0, 8'hFF, 1, 0, 3'd1, 63'h0};
    vecs[1]  = '{"exit7",    64'h7,                    0, 8'hFF, 0, 1, 3'd2, 63'h3};
    vecs[2]  = '{"exit5",    64'h5,                    0, 8'hFF, 0, 1, 3'd2, 63'h2};
    vecs[3]  = '{"addr_p8",  64'h1,                    8, 8'hFF, 0, 0, 3'd0, 63'h0};
    vecs[4]  = '{"addr_p4",  64'h1,                    4, 8'hFF, 0, 0, 3'd0, 63'h0};
    vecs[5]  = '{"strb_fe",  64'h1,                    0, 8'hFE, 0, 0, 3'd0, 63'h0};
    vecs[6]  = '{"clear0",   64'h0,                    0, 8'hFF, 0, 0, 3'd0, 63'h0};
    vecs[7]  = '{"masked3",  64'hFF00_0000_0000_0003, 0, 8'h01, 0, 1, 3'd2, 63'h1};
    vecs[8]  = '{"msb",      64'h8000_0000_0000_0001, 0, 8'hFF, 0, 1, 3'd2, 63'h4000_0000_0000_0000};
    vecs[9]  = '{"syscall",  64'h0000_0000_0000_1000, 0, 8'hFF, 0, 1, 3'd2, 63'h800};
    vecs[10] = '{"mask_pass", 64'h0000_0000_0000_0101, 0, 8'hFD, 1, 0, 3'd1, 63'h0};
`ifdef TOHOST_CONSOLE_EN
    vecs[11] = '{"putchar",  64'h0101_0000_0000_0041, 0, 8'hFF, 0, 0, 3'd0, 63'h0};
`else
    vecs[11] = '{"putchar",  64'h0101_0000_0000_0041, 0, 8'hFF, 0, 1, 3'd2, 63'h0080_8000_0000_0020};
`endif

    do_reset();
    chk_idle("reset");

    for (int i = 0; i < 12; i++) begin
      do_reset();
      run_to(10);
      expect_at(10 + 1 + D, vecs[i].name, vecs[i].fin, vecs[i].fail, vecs[i].rsn, vecs[i].code);
      wr(vecs[i].data, vecs[i].off, vecs[i].strb);
      run_to(20);
    end

    // Pass at cycle 100, then held for 50 cycles despite a later failing write.
    do_reset();
    run_to(100);
    expect_at(105, "pass100", 1, 0, 3'd1, 63'h0);
    wr(64'h1, 0, 8'hFF);
    run_to(106);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (cyc == 110) wr(64'h7, 0, 8'hFF);
      else step();
      if (!(finish === 1'b1 && failure === 1'b0 && reason === 3'd1 && exit_code === 63'h0)) bad++;
    end
    chk("pass_hold", 64'(bad), 64'(0));
    chk("cycles_frozen", cycle_count, 64'd105);
    do_reset();
    chk_idle("reset_in_done");

    // Clear handshake, then pass.
    run_to(10);
    wr(64'h0, 0, 8'hFF);
    run_to(12);
    expect_at(17, "clear_then_pass", 1, 0, 3'd1, 63'h0);
    wr(64'h1, 0, 8'hFF);
    run_to(18);

    // Writes while draining are ignored.
    do_reset();
    run_to(10);
    expect_at(15, "drain_ignore", 1, 0, 3'd1, 63'h0);
    wr(64'h1, 0, 8'hFF);
    run_to(12);
    wr(64'h7, 0, 8'hFF);
    run_to(16);

    // Hang: last retire in cycle 50, event in cycle 70.
    do_reset();
    run_to(51);
    retire_valid = 1'b0;
    run_to(70);
    chk("hang_pre_reason", 64'(reason), 64'(0));
    expect_at(75, "hang", 0, 1, 3'd3, 63'h0);
    step();
    chk("hang_reason_latched", 64'(reason), 64'(3));
    run_to(76);

    // Retire pulse at 65 postpones the hang to cycle 85.
    do_reset();
    run_to(51);
    retire_valid = 1'b0;
    run_to(65);
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    run_to(75);
    chk("no_hang_by_75", 64'(reason), 64'(0));
    expect_at(90, "hang_late", 0, 1, 3'd3, 63'h0);
    run_to(91);

    // Tohost beats hang on the same cycle.
    do_reset();
    run_to(51);
    retire_valid = 1'b0;
    run_to(70);
    expect_at(75, "tohost_vs_hang", 0, 1, 3'd2, 63'h3);
    wr(64'h7, 0, 8'hFF);
    run_to(76);

    // Timeout at cycle 200.
    do_reset();
    max_cycles = 64'd200;
    expect_at(205, "timeout", 0, 1, 3'd4, 63'h0);
    run_to(206);
    chk("timeout_cycles", cycle_count, 64'd205);

    // Tohost beats timeout on the same cycle.
    do_reset();
    max_cycles = 64'd200;
    run_to(200);
    expect_at(205, "tohost_vs_timeout", 1, 0, 3'd1, 63'h0);
    wr(64'h1, 0, 8'hFF);
    run_to(206);

    // Reset during DRAIN aborts the pending pass.
    do_reset();
    run_to(10);
    wr(64'h1, 0, 8'hFF);
    run_to(12);
    chk("drain_reason", 64'(reason), 64'(1));
    do_reset();
    chk_idle("reset_in_drain");
    run_to(5);
    expect_at(10, "after_reset", 0, 1, 3'd2, 63'h2);
    wr(64'h5, 0, 8'hFF);
    run_to(11);

`ifdef TOHOST_CONSOLE_EN
    do_reset();
    run_to(10);
    wr(64'h0101_0000_0000_0041, 0, 8'hFF);
    chk("console_valid", 64'(console_valid), 64'(1));
    chk("console_char", 64'(console_char), 64'h41);
    step();
    chk("console_pulse_end", 64'(console_valid), 64'(0));
    run_to(20);
    chk("console_still_run", 64'({finish, failure, reason}), 64'(0));
    run_to(30);
    expect_at(35, "pass_after_putchar", 1, 0, 3'd1, 63'h0);
    wr(64'h1, 0, 8'hFF);
    run_to(32);
    wr(64'h0101_0000_0000_0042, 0, 8'hFF);
    chk("console_drop_in_drain", 64'(console_valid), 64'(0));
    run_to(36);
`endif

    chk("sb_final", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
